// File: rtl/onehot_sequencer.sv
// Registered binary-to-one-hot decoder with direct, up/down scan and blank modes.
// Scan steps dwell+1 cycles apart; loads through a valid/ready handshake.
module onehot_sequencer #(
    parameter int SEL_W      = 3,
    parameter int DWELL_W    = 16,
    parameter int ACTIVE_LOW = 0
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [1:0]            i_mode,
    input  logic                  i_in_valid,
    output logic                  o_in_ready,
    input  logic [SEL_W-1:0]      i_in_sel,
    input  logic [DWELL_W-1:0]    i_dwell,
    output logic [2**SEL_W-1:0]   o_out_onehot,
    output logic [SEL_W-1:0]      o_out_idx,
    output logic                  o_wrap_pulse
);

    localparam int N = 2**SEL_W;
    localparam logic [N-1:0] INACTIVE = (ACTIVE_LOW != 0) ? {N{1'b1}} : {N{1'b0}};
    localparam logic [SEL_W-1:0] IDX_MAX = {SEL_W{1'b1}};

    typedef enum logic [1:0] {
        MODE_DIRECT    = 2'b00,
        MODE_SCAN_UP   = 2'b01,
        MODE_SCAN_DOWN = 2'b10,
        MODE_BLANK     = 2'b11
    } mode_t;

    mode_t                r_prev_mode;
    logic [SEL_W-1:0]     r_idx;
    logic [DWELL_W-1:0]   r_cnt;
    logic [N-1:0]         r_onehot;
    logic                 r_wrap;
    logic                 r_ready;

    mode_t                w_mode;
    logic                 w_accept;
    logic                 w_mode_chg;
    logic [SEL_W-1:0]     w_idx_nxt;
    logic [DWELL_W-1:0]   w_cnt_nxt;
    logic                 w_wrap_nxt;
    logic [N-1:0]         w_onehot_nxt;

    assign w_mode     = mode_t'(i_mode);
    assign w_accept   = i_in_valid & r_ready;
    assign w_mode_chg = (w_mode != r_prev_mode);

    // Next index, dwell count and wrap flag; accept beats mode change beats scan step.
    always_comb begin
        w_idx_nxt    = r_idx;
        w_cnt_nxt    = {DWELL_W{1'b0}};
        w_wrap_nxt   = 1'b0;
        w_onehot_nxt = INACTIVE;
        if (w_accept) begin
            w_idx_nxt = i_in_sel;
        end else if (w_mode_chg) begin
            w_cnt_nxt = {DWELL_W{1'b0}};
        end else begin
            case (w_mode)
                MODE_SCAN_UP: begin
                    // >= so that a dwell lowered below the running count steps at once
                    if (r_cnt >= i_dwell) begin
                        w_idx_nxt  = r_idx + {{(SEL_W-1){1'b0}}, 1'b1};
                        w_wrap_nxt = (r_idx == IDX_MAX);
                    end else begin
                        w_cnt_nxt = r_cnt + {{(DWELL_W-1){1'b0}}, 1'b1};
                    end
                end
                MODE_SCAN_DOWN: begin
                    if (r_cnt >= i_dwell) begin
                        w_idx_nxt  = r_idx - {{(SEL_W-1){1'b0}}, 1'b1};
                        w_wrap_nxt = (r_idx == {SEL_W{1'b0}});
                    end else begin
                        w_cnt_nxt = r_cnt + {{(DWELL_W-1){1'b0}}, 1'b1};
                    end
                end
                default: begin
                    w_cnt_nxt = {DWELL_W{1'b0}};
                end
            endcase
        end
        if (w_mode == MODE_BLANK) begin
            w_onehot_nxt = INACTIVE;
        end else begin
            w_onehot_nxt = ({{(N-1){1'b0}}, 1'b1} << w_idx_nxt) ^ INACTIVE;
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_idx       <= {SEL_W{1'b0}};
            r_cnt       <= {DWELL_W{1'b0}};
            r_onehot    <= INACTIVE;
            r_wrap      <= 1'b0;
            r_ready     <= 1'b0;
            r_prev_mode <= MODE_BLANK;
        end else begin
            r_idx       <= w_idx_nxt;
            r_cnt       <= w_cnt_nxt;
            r_onehot    <= w_onehot_nxt;
            r_wrap      <= w_wrap_nxt;
            r_ready     <= 1'b1;
            r_prev_mode <= w_mode;
        end
    end

    assign o_in_ready   = r_ready;
    assign o_out_onehot = r_onehot;
    assign o_out_idx    = r_idx;
    assign o_wrap_pulse = r_wrap;

endmodule

// File: tb/tb_onehot_sequencer.sv
// Randomised and directed bench for onehot_sequencer; one active-high and one
// active-low instance share stimulus and are checked against a cycle model.
module tb_onehot_sequencer;

    localparam int N = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  mode = 2'b11;
    logic        valid = 1'b0;
    logic [2:0]  sel = 3'd0;
    logic [15:0] dwell = 16'd0;

    logic        o_ready, o_ready_al, o_wrap, o_wrap_al;
    logic [2:0]  o_idx, o_idx_al;
    logic [7:0]  o_oh, o_oh_al;

    int n_cmp = 0;
    int n_fail = 0;

    // model state
    int m_idx = 0, m_cnt = 0, m_prev = 3;
    bit m_ready = 0, m_wrap = 0, m_blank = 1;

    always #5 clk = ~clk;

    onehot_sequencer #(.SEL_W(3), .DWELL_W(16), .ACTIVE_LOW(0)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_mode(mode), .i_in_valid(valid),
        .o_in_ready(o_ready), .i_in_sel(sel), .i_dwell(dwell),
        .o_out_onehot(o_oh), .o_out_idx(o_idx), .o_wrap_pulse(o_wrap));

    onehot_sequencer #(.SEL_W(3), .DWELL_W(16), .ACTIVE_LOW(1)) dut_al (
        .i_clk(clk), .i_rst_n(rst_n), .i_mode(mode), .i_in_valid(valid),
        .o_in_ready(o_ready_al), .i_in_sel(sel), .i_dwell(dwell),
        .o_out_onehot(o_oh_al), .o_out_idx(o_idx_al), .o_wrap_pulse(o_wrap_al));

    function automatic logic [25:0] dut_vec();
        return {o_idx, o_oh, o_wrap, o_ready, o_idx_al, o_oh_al, o_wrap_al, o_ready_al};
    endfunction

    function automatic logic [25:0] model_vec();
        logic [7:0] oh;
        logic [2:0] ix;
        ix = 3'(m_idx);
        oh = m_blank ? 8'h00 : 8'(1 << m_idx);
        return {ix, oh, m_wrap, m_ready, ix, ~oh, m_wrap, m_ready};
    endfunction

    // One clock edge: advance the model from the current inputs, then sample after the edge.
    task automatic tick();
        int  n_idx = m_idx;
        int  n_cnt = 0;
        bit  n_wrap = 0;
        if (!rst_n) begin
            n_idx = 0;
        end else if (valid && m_ready) begin
            n_idx = sel;
        end else if (int'(mode) != m_prev) begin
            n_cnt = 0;
        end else if (mode == 2'b01 || mode == 2'b10) begin
            if (m_cnt >= int'(dwell)) begin
                if (mode == 2'b01) begin
                    n_wrap = (m_idx == N - 1);
                    n_idx  = (m_idx + 1) % N;
                end else begin
                    n_wrap = (m_idx == 0);
                    n_idx  = (m_idx + N - 1) % N;
                end
            end else begin
                n_cnt = m_cnt + 1;
            end
        end
        @(posedge clk);
        #1;
        m_idx   = n_idx;
        m_cnt   = n_cnt;
        m_wrap  = n_wrap;
        m_ready = rst_n;
        m_prev  = rst_n ? int'(mode) : 3;
        m_blank = !rst_n || (mode == 2'b11);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; mode = 2'b00; valid = 1'b1; sel = 3'd5;
        tick();
        n_cmp++;
        if ({o_idx, o_oh, o_oh_al, o_ready, o_wrap} !== {3'd0, 8'h00, 8'hFF, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset: got %h required %h", {o_idx, o_oh, o_oh_al, o_ready, o_wrap},
                     {3'd0, 8'h00, 8'hFF, 1'b0, 1'b0});
        end
        rst_n = 1'b1; valid = 1'b0;
        tick();
        n_cmp++;
        if (dut_vec() !== model_vec()) begin
            n_fail++;
            $display("FAIL reset_release: got %h required %h", dut_vec(), model_vec());
        end
    endtask

    task automatic test_direct();
        mode = 2'b00;
        for (int s = 0; s < N; s++) begin
            valid = 1'b1; sel = 3'(s);
            tick();
            n_cmp++;
            if (o_oh !== 8'(1 << s) || o_idx !== 3'(s) || dut_vec() !== model_vec()) begin
                n_fail++;
                $display("FAIL direct sel=%0d: got oh=%b idx=%0d required oh=%b idx=%0d",
                         s, o_oh, o_idx, 8'(1 << s), s);
            end
        end
        valid = 1'b0;
    endtask

    task automatic test_scan_up();
        int exp_idx[10] = '{6, 6, 6, 7, 7, 7, 0, 0, 0, 1};
        mode = 2'b01; dwell = 16'd2;
        tick();
        valid = 1'b1; sel = 3'd6;
        for (int i = 0; i < 10; i++) begin
            if (i > 0) valid = 1'b0;
            tick();
            n_cmp++;
            if (o_idx !== 3'(exp_idx[i]) || o_wrap !== (i == 6) || dut_vec() !== model_vec()) begin
                n_fail++;
                $display("FAIL scan_up step %0d: got idx=%0d wrap=%b required idx=%0d wrap=%b",
                         i, o_idx, o_wrap, exp_idx[i], (i == 6));
            end
        end
    endtask

    task automatic test_scan_down();
        int exp_idx[4] = '{1, 0, 7, 6};
        mode = 2'b10; dwell = 16'd0;
        tick();
        valid = 1'b1; sel = 3'd1;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) valid = 1'b0;
            tick();
            n_cmp++;
            if (o_idx !== 3'(exp_idx[i]) || o_wrap !== (i == 2) || dut_vec() !== model_vec()) begin
                n_fail++;
                $display("FAIL scan_down step %0d: got idx=%0d wrap=%b required idx=%0d wrap=%b",
                         i, o_idx, o_wrap, exp_idx[i], (i == 2));
            end
        end
    endtask

    task automatic test_accept_priority();
        mode = 2'b01; dwell = 16'd3;
        tick();
        valid = 1'b1; sel = 3'd0;
        tick();
        valid = 1'b0;
        repeat (3) tick();
        valid = 1'b1; sel = 3'd4;
        tick();
        valid = 1'b0;
        n_cmp++;
        if (o_idx !== 3'd4 || o_wrap !== 1'b0 || dut_vec() !== model_vec()) begin
            n_fail++;
            $display("FAIL accept_priority: got idx=%0d wrap=%b required idx=4 wrap=0", o_idx, o_wrap);
        end
        repeat (3) tick();
        n_cmp++;
        if (o_idx !== 3'd4) begin
            n_fail++;
            $display("FAIL accept_restart_hold: got idx=%0d required 4", o_idx);
        end
        tick();
        n_cmp++;
        if (o_idx !== 3'd5 || dut_vec() !== model_vec()) begin
            n_fail++;
            $display("FAIL accept_restart_step: got idx=%0d required 5", o_idx);
        end
    endtask

    task automatic test_blank();
        mode = 2'b11;
        tick();
        n_cmp++;
        if (o_oh_al !== 8'hFF || o_oh !== 8'h00) begin
            n_fail++;
            $display("FAIL blank: got al=%h hi=%h required al=ff hi=00", o_oh_al, o_oh);
        end
        valid = 1'b1; sel = 3'd2;
        tick();
        valid = 1'b0;
        n_cmp++;
        if (o_idx_al !== 3'd2 || o_oh_al !== 8'hFF) begin
            n_fail++;
            $display("FAIL blank_accept: got idx=%0d al=%h required idx=2 al=ff", o_idx_al, o_oh_al);
        end
        mode = 2'b00;
        tick();
        n_cmp++;
        if (o_oh_al !== 8'b11111011 || o_oh !== 8'b00000100 || dut_vec() !== model_vec()) begin
            n_fail++;
            $display("FAIL blank_to_direct: got al=%b hi=%b required al=11111011 hi=00000100",
                     o_oh_al, o_oh);
        end
    endtask

    task automatic test_reset_midscan();
        mode = 2'b01; dwell = 16'd1;
        tick();
        valid = 1'b1; sel = 3'd5;
        tick();
        valid = 1'b0;
        tick();
        rst_n = 1'b0;
        tick();
        n_cmp++;
        if ({o_idx, o_oh, o_oh_al, o_ready, o_wrap} !== {3'd0, 8'h00, 8'hFF, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_midscan: got %h required %h", {o_idx, o_oh, o_oh_al, o_ready, o_wrap},
                     {3'd0, 8'h00, 8'hFF, 1'b0, 1'b0});
        end
        rst_n = 1'b1;
        tick();
        n_cmp++;
        if (dut_vec() !== model_vec()) begin
            n_fail++;
            $display("FAIL reset_midscan_release: got %h required %h", dut_vec(), model_vec());
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            rst_n = ($urandom_range(0, 63) != 0);
            if ($urandom_range(0, 15) == 0) mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 15) == 0) dwell = 16'($urandom_range(0, 4));
            valid = ($urandom_range(0, 7) == 0);
            sel = 3'($urandom_range(0, N - 1));
            tick();
            n_cmp++;
            if (dut_vec() !== model_vec()) begin
                n_fail++;
                $display("FAIL random cycle %0d: got %h required %h", i, dut_vec(), model_vec());
            end
        end
        rst_n = 1'b1; valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_direct();
        test_scan_up();
        test_scan_down();
        test_accept_priority();
        test_blank();
        test_reset_midscan();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/onehot_sequencer.md
# onehot_sequencer

Parametrised binary-to-one-hot decoder with a registered, glitch-free output and three run modes: direct decode, automatic up/down scan with programmable dwell, and blank. It generalises the fixed 3-to-8 decoder to 2^SEL_W outputs. It drives LED banks and select lines on the board where a stable registered one-hot value, or a self-running chaser, is needed.

## Interface
- SEL_W, 3, index width; output width is 2^SEL_W
- DWELL_W, 16, dwell counter width
- ACTIVE_LOW, 0, 1 inverts every bit of out_onehot (active bit 0, inactive bits 1)
- clk  in  1  single clock, all state on rising edge
- rst_n  in  1  synchronous, active-low reset
- mode  in  2  00 DIRECT, 01 SCAN_UP, 10 SCAN_DOWN, 11 BLANK; sampled every cycle
- in_valid  in  1  in_sel is valid
- in_ready  out  1  load accepted when in_valid && in_ready
- in_sel  in  SEL_W  index to load
- dwell  in  DWELL_W  scan hold time; each index is shown for dwell+1 cycles
- out_onehot  out  2^SEL_W  registered one-hot of out_idx (all inactive in BLANK)
- out_idx  out  SEL_W  current index register
- wrap_pulse  out  1  one-cycle pulse when a scan step wraps

## Operation
- State: idx register, dwell counter cnt, registered out_onehot, wrap_pulse, and prev_mode for change detection.
- in_ready is 0 while rst_n=0. It is 1 on every cycle after reset in all modes.
- Accept (in_valid && in_ready): idx <= in_sel and cnt <= 0. An accept has priority over a scan step in the same cycle. No wrap_pulse is produced by an accept.
- DIRECT: idx changes only by accept. cnt is held at 0.
- SCAN_UP / SCAN_DOWN: with no accept, cnt increments each cycle.
  - When cnt >= dwell, cnt <= 0 and idx steps by +1 (UP) or -1 (DOWN), modulo 2^SEL_W.
  - The >= comparison makes a dwell reduced below the current cnt step on the next cycle.
  - dwell=0 steps every cycle.
- wrap_pulse=1 for one cycle, registered with the step, when UP steps max→0 or DOWN steps 0→max.
- BLANK: out_onehot is all inactive. Accepts still update idx and out_idx. cnt is held at 0.
- Mode change: on any cycle where mode differs from the previous cycle, cnt <= 0 and no step occurs. idx is retained.
- out_onehot next value = decode(next idx), or all inactive if next mode is BLANK. ACTIVE_LOW inversion is applied last.
- Exactly one bit is active whenever the mode is not BLANK.

## Timing
- Reset values:
  - idx=0, cnt=0, wrap_pulse=0, in_ready=0.
  - out_onehot all inactive (0s, or all 1s if ACTIVE_LOW).
  - prev_mode=BLANK.
- Reset asserted mid-scan takes effect at the next edge. It overrides accept and step.
- Latency: in_sel accepted at edge k appears on out_idx and out_onehot after edge k. There is one register stage and no combinational path from in_sel to out_onehot.
- Scan period per index is dwell+1 cycles. A full sweep takes 2^SEL_W·(dwell+1) cycles.
- A changed dwell value takes effect on the next compare, with no restart.
- The first step after entering a scan mode occurs dwell+1 cycles after the mode-change cycle.
- wrap_pulse is aligned with the out_idx update it describes.

## Test plan
- Reset then DIRECT, SEL_W=3: sweep in_sel 0..7 with in_valid=1. Each accept yields out_onehot=1<<in_sel one cycle later, e.g. 5 → 8'b00100000.
- SCAN_UP, dwell=2, from idx 6: 6 is held 3 cycles, then 7, then 0 with wrap_pulse=1 for exactly one cycle, then 1.
- SCAN_DOWN, dwell=0, from idx 1: sequence 1,0,7,6 on consecutive cycles, with wrap_pulse only on the 0→7 step.
- SCAN_UP, dwell=3: an accept of in_sel=4 on the same cycle a step is due gives out_idx=4, no step, and cnt restarted.
- BLANK with ACTIVE_LOW=1: out_onehot=8'hFF. Accept in_sel=2, then switch to DIRECT: out_onehot=8'b11111011 on the first cycle.
- rst_n=0 for one cycle mid-scan at idx 5: next cycle idx=0, out_onehot inactive, in_ready=0, wrap_pulse=0.
